puf_challenge_sequencer: RTL
============================

# puf_challenge_sequencer

Upstream driver for the `mapping` PUF core. It assembles an IN_WIDTH-bit challenge from a serial bit stream and fires a one-cycle `trigger` into `mapping`. It then waits for the core's `done`, captures the OUT_WIDTH-bit response, and presents it with a valid pulse. If the core never answers, it flags a timeout. It replaces the ad-hoc challenge counter logic at the top level.

## Interface
Parameters:
- IN_WIDTH, 128, challenge width in bits; must match `mapping` IN_WIDTH.
- OUT_WIDTH, 16, response width in bits; must match `mapping` OUT_WIDTH.
- TIMEOUT, 1023, maximum WAIT cycles before abort; range 1..65535.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a new challenge load; honoured only in IDLE.
- bit_in  in  1  serial challenge bit.
- bit_valid  in  1  bit_in is sampled when this is high in SHIFT.
- done  in  1  from `mapping`; response is valid in the cycle it is high.
- dataIn  in  OUT_WIDTH  response from `mapping`.
- dataOut  out  IN_WIDTH  challenge to `mapping`.
- trigger  out  1  one-cycle start pulse to `mapping`.
- resp  out  OUT_WIDTH  last captured response.
- resp_valid  out  1  one-cycle pulse when resp updates.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky abort flag.

## Operation
- All outputs are registered.
- Reset values: dataOut=0, trigger=0, resp=0, resp_valid=0, busy=0, timeout_err=0, state=IDLE, bit counter=0, wait timer=0.
- State machine: IDLE -> SHIFT -> FIRE -> WAIT -> IDLE.
- IDLE
  - On start=1: clear the bit counter and timeout_err, go to SHIFT.
  - done is ignored in IDLE.
- SHIFT
  - Each edge with bit_valid=1: dataOut[cnt] <= bit_in, then cnt <= cnt+1. Bit 0 is the first bit received (LSB first).
  - Edges with bit_valid=0 hold all state.
  - Bit positions not yet written keep their previous values. dataOut is not cleared on start.
  - When the bit accepted has cnt = IN_WIDTH-1: go to FIRE.
  - The counter is $clog2(IN_WIDTH) bits wide and never wraps past IN_WIDTH-1.
- FIRE
  - trigger=1 for exactly this one cycle.
  - Clear the wait timer, go to WAIT.
  - dataOut is stable from FIRE until the next start.
- WAIT
  - Timer increments every edge.
  - done=1: resp <= dataIn, resp_valid=1 for one cycle, go to IDLE.
  - Timer reaches TIMEOUT with no done: set timeout_err, go to IDLE; resp is unchanged.
  - done and timeout on the same edge: done wins, and timeout_err stays 0.
- start outside IDLE is ignored, with no restart.
- Reset asserted mid-operation returns everything to reset values immediately; the partial challenge is lost.

## Timing
- start sampled at edge N: busy=1 and state=SHIFT from edge N. The first bit can be accepted at edge N+1.
- Last bit accepted at edge M: trigger high from edge M to M+1.
- WAIT starts at edge M+1.
- Minimum start-to-trigger latency is IN_WIDTH+1 edges, reached with bit_valid held high.
- done sampled at edge K: resp, resp_valid=1 and busy=0 all take effect at edge K. resp_valid drops at edge K+1.
- Timeout: with no done, timeout_err=1 and busy=0 at the TIMEOUT-th edge after WAIT entry.
- Back-to-back: start may be asserted on the edge after resp_valid, giving zero idle overhead beyond one IDLE cycle.

## Test plan
- Reset, then start plus 128 bits of pattern 0x0000...FFFF0000 (LSB first, bit_valid held high) -> dataOut=128'hFFFF0000 and trigger pulses once, 129 edges after start.
- bit_valid toggled 1/0 every cycle during SHIFT -> challenge identical to the continuous case; trigger delayed to 257 edges after start.
- Model `mapping` answering done 10 cycles after trigger with dataIn=16'hA5C3 -> resp=16'hA5C3, resp_valid high exactly one cycle, busy falls on the same edge.
- done never asserted, TIMEOUT=8 -> timeout_err=1 after 8 WAIT edges; resp keeps its prior value. Next start clears timeout_err.
- start pulsed during SHIFT and WAIT -> no effect on counter or state. done pulsed in IDLE -> resp and resp_valid unchanged.
- reset driven low mid-SHIFT, asynchronously between edges -> all outputs 0 immediately. After release, a full load completes normally.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - serial challenge loader and response capture for the mapping PUF core
module puf_challenge_sequencer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 done,
    input  logic [OUT_WIDTH-1:0] dataIn,
    output logic [IN_WIDTH-1:0]  dataOut,
    output logic                 trigger,
    output logic [OUT_WIDTH-1:0] resp,
    output logic                 resp_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(IN_WIDTH - 1);
    // Timer counts WAIT edges; abort is taken on the edge where it has seen TIMEOUT-1
    localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIRE  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           timer_q, timer_d;
    logic [IN_WIDTH-1:0]   data_q, data_d;
    logic                  trig_q, trig_d;
    logic [OUT_WIDTH-1:0]  resp_q, resp_d;
    logic                  rv_q, rv_d;
    logic                  busy_q, busy_d;
    logic                  to_q, to_d;

    // Next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        data_d  = data_q;
        trig_d  = 1'b0;
        resp_d  = resp_q;
        rv_d    = 1'b0;
        busy_d  = busy_q;
        to_d    = to_q;

        case (state_q)
            S_IDLE: begin
                // done is deliberately ignored here; a late answer must not update resp
                if (start) begin
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_valid) begin
                    // LSB first; untouched positions keep whatever the previous challenge left
                    data_d[cnt_q] = bit_in;
                    if (cnt_q == LAST_BIT) begin
                        // Counter parks at the last index instead of wrapping
                        trig_d  = 1'b1;
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_FIRE: begin
                // trigger is already high for this cycle; arm the response timer
                timer_d = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (done) begin
                    // A response on the final timer edge still counts as a success
                    resp_d  = dataIn;
                    rv_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset discards any partial challenge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            trig_q  <= 1'b0;
            resp_q  <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            trig_q  <= trig_d;
            resp_q  <= resp_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign dataOut     = data_q;
    assign trigger     = trig_q;
    assign resp        = resp_q;
    assign resp_valid  = rv_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;

endmodule
